// File: rtl/ascon_pkg.sv
// Shared constants for the Ascon serial load/unload front-end.
package ascon_pkg;

    localparam int NONCE_BITS = 128;
    localparam int TAG_BITS   = 128;

    // Field select codes carried on din_sel
    localparam logic [1:0] FLD_KEY   = 2'd0;
    localparam logic [1:0] FLD_NONCE = 2'd1;
    localparam logic [1:0] FLD_AD    = 2'd2;
    localparam logic [1:0] FLD_TEXT  = 2'd3;

    // Controller states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_ARMED  = 3'd2;
    localparam logic [2:0] ST_BUSY   = 3'd3;
    localparam logic [2:0] ST_UNLOAD = 3'd4;

endpackage

// File: rtl/ascon_share_shreg.sv
// SHARES parallel MSB-first shift registers for one operand field, with a
// word counter and a loaded flag. Writes after the field is full are dropped.
module ascon_share_shreg
    import ascon_pkg::*;
#(
    parameter int LEN    = 128,
    parameter int W      = 8,
    parameter int SHARES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic [SHARES*W-1:0]   din,
    output logic [SHARES*LEN-1:0] sh,
    output logic                  loaded
);

    localparam int WORDS = LEN / W;
    localparam int CW    = $clog2(WORDS + 1);

    logic [SHARES*LEN-1:0] sh_q, sh_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  loaded_q, loaded_d;

    // Next-state: clear wins, otherwise shift one word into every share
    always_comb begin
        sh_d     = sh_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        if (clr) begin
            sh_d     = '0;
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else if (en && !loaded_q) begin
            for (int s = 0; s < SHARES; s++) begin
                sh_d[s*LEN +: LEN] = (sh_q[s*LEN +: LEN] << W) | LEN'(din[s*W +: W]);
            end
            cnt_d    = cnt_q + 1'b1;
            loaded_d = (cnt_d == CW'(WORDS));
        end
    end

    // Field state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
        end else begin
            sh_q     <= sh_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end

    assign sh     = sh_q;
    assign loaded = loaded_q;

endmodule

// File: rtl/ascon_serial_io.sv
// Serial load/unload front-end for the masked Ascon AEAD core.
//   state     | meaning
//   IDLE      | empty, waiting for the first load beat
//   LOAD      | collecting key/nonce/AD/text words in any order
//   ARMED     | all fields full, waiting for start_enc/start_dec
//   BUSY      | core running, waiting for core_done
//   UNLOAD    | streaming text (and tag on encrypt) out under backpressure
module ascon_serial_io
    import ascon_pkg::*;
#(
    parameter int W        = 8,
    parameter int SHARES   = 2,
    parameter int KEY_BITS = 128,
    parameter int AD_BITS  = 32,
    parameter int PT_BITS  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SHARES*W-1:0]          din,
    input  logic [1:0]                   din_sel,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         start_enc,
    input  logic                         start_dec,
    output logic [SHARES*KEY_BITS-1:0]   key_sh,
    output logic [SHARES*NONCE_BITS-1:0] nonce_sh,
    output logic [SHARES*AD_BITS-1:0]    ad_sh,
    output logic [SHARES*PT_BITS-1:0]    text_sh,
    output logic                         core_start,
    output logic                         core_dec,
    input  logic                         core_done,
    input  logic [PT_BITS-1:0]           core_text,
    input  logic [TAG_BITS-1:0]          core_tag,
    input  logic                         core_auth_ok,
    output logic [W-1:0]                 dout,
    output logic                         dout_valid,
    output logic                         dout_last,
    input  logic                         dout_ready,
    output logic                         auth_fail,
    output logic                         err
);

    if ((KEY_BITS % W) != 0 || (NONCE_BITS % W) != 0 || (AD_BITS % W) != 0 ||
        (PT_BITS % W) != 0) begin : g_bad_width
        $error("ascon_serial_io: W must divide every field length");
    end
    if (SHARES < 1 || SHARES > 5) begin : g_bad_shares
        $error("ascon_serial_io: SHARES must be 1..5");
    end

    localparam int OUT_BITS  = PT_BITS + TAG_BITS;
    localparam int PT_WORDS  = PT_BITS / W;
    localparam int ALL_WORDS = OUT_BITS / W;
    localparam int BW        = $clog2(ALL_WORDS + 1);

    logic [2:0]          state_q, state_d;
    logic                core_start_q, core_start_d;
    logic                core_dec_q, core_dec_d;
    logic                dec_q, dec_d;
    logic                auth_fail_q, auth_fail_d;
    logic                err_q, err_d;
    logic [OUT_BITS-1:0] out_q, out_d;
    logic [BW-1:0]       beat_q, beat_d;

    logic       accept, overflow, clr_fields, last_beat;
    logic [3:0] loaded, fld_en;

    assign din_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept    = din_valid && din_ready;
    assign overflow  = accept && loaded[din_sel];
    assign last_beat = (beat_q == (dec_q ? BW'(PT_WORDS - 1) : BW'(ALL_WORDS - 1)));

    // One-hot write enable towards the addressed field
    always_comb begin
        fld_en = '0;
        fld_en[din_sel] = accept;
    end

    ascon_share_shreg #(.LEN(KEY_BITS), .W(W), .SHARES(SHARES)) u_key (
        .clk(clk), .rst(rst), .clr(clr_fields), .en(fld_en[FLD_KEY]), .din(din),
        .sh(key_sh), .loaded(loaded[FLD_KEY]));
    ascon_share_shreg #(.LEN(NONCE_BITS), .W(W), .SHARES(SHARES)) u_nonce (
        .clk(clk), .rst(rst), .clr(clr_fields), .en(fld_en[FLD_NONCE]), .din(din),
        .sh(nonce_sh), .loaded(loaded[FLD_NONCE]));
    ascon_share_shreg #(.LEN(AD_BITS), .W(W), .SHARES(SHARES)) u_ad (
        .clk(clk), .rst(rst), .clr(clr_fields), .en(fld_en[FLD_AD]), .din(din),
        .sh(ad_sh), .loaded(loaded[FLD_AD]));
    ascon_share_shreg #(.LEN(PT_BITS), .W(W), .SHARES(SHARES)) u_text (
        .clk(clk), .rst(rst), .clr(clr_fields), .en(fld_en[FLD_TEXT]), .din(din),
        .sh(text_sh), .loaded(loaded[FLD_TEXT]));

    // Sequencing, launch, result capture and output serialisation
    always_comb begin
        state_d      = state_q;
        core_start_d = 1'b0;
        core_dec_d   = core_dec_q;
        dec_d        = dec_q;
        auth_fail_d  = auth_fail_q;
        err_d        = err_q;
        out_d        = out_q;
        beat_d       = beat_q;
        clr_fields   = 1'b0;

        if (overflow) err_d = 1'b1;
        if ((start_enc || start_dec) && state_q != ST_ARMED) err_d = 1'b1;
        if (core_done && state_q != ST_BUSY) err_d = 1'b1;

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_LOAD;
            ST_LOAD: if (&loaded) state_d = ST_ARMED;
            ST_ARMED: begin
                if (start_enc && start_dec) begin
                    err_d = 1'b1;
                end else if (start_enc || start_dec) begin
                    state_d      = ST_BUSY;
                    core_start_d = 1'b1;
                    core_dec_d   = start_dec;
                    dec_d        = start_dec;
                    auth_fail_d  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (core_done) begin
                    state_d     = ST_UNLOAD;
                    core_dec_d  = 1'b0;
                    auth_fail_d = dec_q && !core_auth_ok;
                    beat_d      = '0;
                    // A failed decrypt never exposes the candidate plaintext
                    if (!dec_q)           out_d = {core_text, core_tag};
                    else if (core_auth_ok) out_d = {core_text, {TAG_BITS{1'b0}}};
                    else                  out_d = '0;
                end
            end
            ST_UNLOAD: begin
                if (dout_ready) begin
                    out_d  = out_q << W;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d    = ST_IDLE;
                        out_d      = '0;
                        beat_d     = '0;
                        clr_fields = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            core_dec_q   <= 1'b0;
            dec_q        <= 1'b0;
            auth_fail_q  <= 1'b0;
            err_q        <= 1'b0;
            out_q        <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            core_start_q <= core_start_d;
            core_dec_q   <= core_dec_d;
            dec_q        <= dec_d;
            auth_fail_q  <= auth_fail_d;
            err_q        <= err_d;
            out_q        <= out_d;
            beat_q       <= beat_d;
        end
    end

    assign core_start = core_start_q;
    assign core_dec   = core_dec_q;
    assign auth_fail  = auth_fail_q;
    assign err        = err_q;
    assign dout_valid = (state_q == ST_UNLOAD);
    assign dout       = dout_valid ? out_q[OUT_BITS-1 -: W] : '0;
    assign dout_last  = dout_valid && last_beat;

endmodule

// File: tb/tb_ascon_serial_io.sv
// Directed bench for ascon_serial_io with W=8, SHARES=2, AD/PT = 32 bits.
module tb_ascon_serial_io;
    import ascon_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  din = '0;
    logic [1:0]   din_sel = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         start_enc = 1'b0, start_dec = 1'b0;
    logic [255:0] key_sh, nonce_sh;
    logic [63:0]  ad_sh, text_sh;
    logic         core_start, core_dec;
    logic         core_done = 1'b0;
    logic [31:0]  core_text = '0;
    logic [127:0] core_tag = '0;
    logic         core_auth_ok = 1'b0;
    logic [7:0]   dout;
    logic         dout_valid, dout_last;
    logic         dout_ready = 1'b0;
    logic         auth_fail, err;

    int n_checks = 0;
    int n_err    = 0;

    logic [127:0] exp_key0, exp_key1, exp_nonce0;
    logic [31:0]  exp_ad0, exp_text1;

    typedef struct {
        logic         dec;
        logic         auth_ok;
        logic [31:0]  text;
        logic [127:0] tag;
        int           stall_beat;
        int           exp_beats;
        logic         exp_auth_fail;
    } sc_t;
    sc_t tbl[4];

    ascon_serial_io #(.W(8), .SHARES(2), .KEY_BITS(128), .AD_BITS(32), .PT_BITS(32)) dut (
        .clk(clk), .rst(rst), .din(din), .din_sel(din_sel), .din_valid(din_valid),
        .din_ready(din_ready), .start_enc(start_enc), .start_dec(start_dec),
        .key_sh(key_sh), .nonce_sh(nonce_sh), .ad_sh(ad_sh), .text_sh(text_sh),
        .core_start(core_start), .core_dec(core_dec), .core_done(core_done),
        .core_text(core_text), .core_tag(core_tag), .core_auth_ok(core_auth_ok),
        .dout(dout), .dout_valid(dout_valid), .dout_last(dout_last),
        .dout_ready(dout_ready), .auth_fail(auth_fail), .err(err));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] sel, input logic [7:0] b0, input logic [7:0] b1);
        din       = {b1, b0};
        din_sel   = sel;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Interleaved load of all four fields: 40 beats, then ARMED two edges later
    task automatic load_all();
        logic [7:0] b0, b1;
        exp_key0 = '0; exp_key1 = '0; exp_nonce0 = '0; exp_ad0 = '0; exp_text1 = '0;
        for (int i = 0; i < 16; i++) begin
            b0 = 8'(8'h10 + i); b1 = 8'(8'hA0 ^ i);
            send(FLD_KEY, b0, b1);
            exp_key0 = {exp_key0[119:0], b0};
            exp_key1 = {exp_key1[119:0], b1};
            b0 = 8'(8'h40 + i);
            send(FLD_NONCE, b0, 8'(8'h80 + i));
            exp_nonce0 = {exp_nonce0[119:0], b0};
            if (i < 4) begin
                b0 = 8'(8'hC0 + i);
                send(FLD_AD, b0, 8'h5A);
                exp_ad0 = {exp_ad0[23:0], b0};
                b1 = 8'(8'hE0 + i);
                send(FLD_TEXT, 8'h33, b1);
                exp_text1 = {exp_text1[23:0], b1};
            end
        end
        chk("key_share0", key_sh[127:0], exp_key0);
        chk("key_share1", key_sh[255:128], exp_key1);
        chk("nonce_share0", nonce_sh[127:0], exp_nonce0);
        chk("ad_share0", ad_sh[31:0], exp_ad0);
        chk("text_share1", text_sh[63:32], exp_text1);
        chk("not_armed_yet", din_ready, 1'b1);
        tick();
        chk("armed_after_2", din_ready, 1'b0);
    endtask

    function automatic logic [7:0] exp_word(input sc_t s, input int i);
        logic [159:0] full;
        full = {s.text, s.tag};
        if (s.dec && !s.auth_ok) return 8'h00;
        return full[159 - 8*i -: 8];
    endfunction

    task automatic run_sc(input int k);
        sc_t s;
        int  beat, cyc, left;
        bit  stalled;
        s = tbl[k];
        load_all();
        if (s.dec) start_dec = 1'b1; else start_enc = 1'b1;
        tick();
        start_enc = 1'b0; start_dec = 1'b0;
        chk("core_start_pulse", core_start, 1'b1);
        chk("core_dec", core_dec, s.dec);
        chk("auth_fail_clr_on_launch", auth_fail, 1'b0);
        tick();
        chk("core_start_single", core_start, 1'b0);
        chk("busy_no_valid", dout_valid, 1'b0);
        core_text = s.text; core_tag = s.tag; core_auth_ok = s.auth_ok; core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("first_valid", dout_valid, 1'b1);
        beat = 0; cyc = 0; left = 0; stalled = 0;
        while (beat < s.exp_beats && cyc < 100) begin
            if (beat == s.stall_beat && !stalled) begin
                stalled = 1; left = 3;
            end
            dout_ready = (left == 0);
            if (left > 0) left--;
            if (!dout_valid) begin
                chk("valid_dropped", dout_valid, 1'b1);
                break;
            end
            if (dout_ready) begin
                chk($sformatf("dout_beat%0d", beat), dout, exp_word(s, beat));
                chk($sformatf("last_beat%0d", beat), dout_last, (beat == s.exp_beats - 1));
                beat++;
            end else begin
                chk("dout_hold", dout, exp_word(s, beat));
                chk("last_hold", dout_last, (beat == s.exp_beats - 1));
            end
            tick();
            cyc++;
        end
        dout_ready = 1'b0;
        chk("beat_count", beat, s.exp_beats);
        chk("no_extra_beat", dout_valid, 1'b0);
        chk("auth_fail", auth_fail, s.exp_auth_fail);
        chk("key_cleared", key_sh, '0);
        chk("nonce_cleared", nonce_sh, '0);
        chk("idle_ready", din_ready, 1'b1);
        chk("no_err", err, 1'b0);
    endtask

    initial begin
        tbl[0] = '{dec: 1'b0, auth_ok: 1'b1, text: 32'hDEADBEEF,
                   tag: 128'h00112233_44556677_8899AABB_CCDDEEFF,
                   stall_beat: 1, exp_beats: 20, exp_auth_fail: 1'b0};
        tbl[1] = '{dec: 1'b1, auth_ok: 1'b0, text: 32'h12345678,
                   tag: 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000,
                   stall_beat: -1, exp_beats: 4, exp_auth_fail: 1'b1};
        tbl[2] = '{dec: 1'b1, auth_ok: 1'b1, text: 32'hCAFEF00D,
                   tag: 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
                   stall_beat: 2, exp_beats: 4, exp_auth_fail: 1'b0};
        tbl[3] = '{dec: 1'b0, auth_ok: 1'b0, text: 32'h0102A5FF,
                   tag: 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978,
                   stall_beat: 19, exp_beats: 20, exp_auth_fail: 1'b0};

        do_reset();
        chk("rst_din_ready", din_ready, 1'b1);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_dec", core_dec, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_valid", dout_valid, 1'b0);
        chk("rst_dout_last", dout_last, 1'b0);
        chk("rst_auth_fail", auth_fail, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_key_sh", key_sh, '0);

        for (int k = 0; k < 4; k++) run_sc(k);

        // 5th AD word is dropped and flags an error
        do_reset();
        for (int i = 0; i < 4; i++) send(FLD_AD, 8'(8'hC0 + i), 8'h5A);
        chk("ad_full_no_err", err, 1'b0);
        send(FLD_AD, 8'h99, 8'h77);
        chk("ad_overflow_err", err, 1'b1);
        chk("ad_overflow_dropped", ad_sh, {32'h5A5A5A5A, 32'hC0C1C2C3});

        // start while still loading
        do_reset();
        send(FLD_KEY, 8'h01, 8'h02);
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("start_in_load_err", err, 1'b1);
        chk("start_in_load_no_pulse", core_start, 1'b0);

        // core_done while idle
        do_reset();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done_in_idle_err", err, 1'b1);

        // both starts together: stays ARMED, a later single start still launches
        do_reset();
        load_all();
        start_enc = 1'b1; start_dec = 1'b1;
        tick();
        start_enc = 1'b0; start_dec = 1'b0;
        chk("both_start_no_pulse", core_start, 1'b0);
        chk("both_start_err", err, 1'b1);
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("still_armed_launch", core_start, 1'b1);

        // reset in the middle of unloading
        do_reset();
        load_all();
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        tick();
        core_text = 32'hDEADBEEF; core_tag = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        dout_ready = 1'b1;
        repeat (5) tick();
        chk("mid_unload_beat6", dout, 8'h11);
        dout_ready = 1'b0;
        start_enc = 1'b1;
        tick();
        start_enc = 1'b0;
        chk("start_in_unload_err", err, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_valid", dout_valid, 1'b0);
        chk("rst_mid_err", err, 1'b0);
        chk("rst_mid_ready", din_ready, 1'b1);
        chk("rst_mid_key", key_sh, '0);
        chk("rst_mid_nonce", nonce_sh, '0);
        chk("rst_mid_ad_text", {ad_sh, text_sh}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ascon_serial_io.md
# ascon_serial_io

Parametrised serial load/unload front-end for the masked Ascon AEAD core. It accepts key, nonce, associated data and text as W-bit words per share, in any field order, and holds the shared operands for the core. It launches one encryption or decryption, captures the core result, then streams text and tag back out W bits per beat under valid/ready backpressure. On a failed decryption it releases zeros instead of plaintext.

## Interface
- W, 8: bits per share per transfer beat; must divide KEY_BITS, 128, AD_BITS, PT_BITS (elaboration error otherwise)
- SHARES, 2: masking shares per operand, 1..5
- KEY_BITS, 128: key length
- AD_BITS, 32: associated-data length
- PT_BITS, 32: plaintext/ciphertext length
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- din  in  SHARES*W  load word; share s on din[s*W +: W]
- din_sel  in  2  field select: 0 key, 1 nonce, 2 AD, 3 text
- din_valid  in  1  load strobe
- din_ready  out  1  high in IDLE/LOAD
- start_enc / start_dec  in  1 each  launch request
- key_sh / nonce_sh / ad_sh / text_sh  out  SHARES*len each  share s at [s*len +: len]
- core_start  out  1  one-cycle launch pulse
- core_dec  out  1  0 encrypt, 1 decrypt; valid with core_start, held until core_done
- core_done  in  1  one-cycle completion pulse
- core_text  in  PT_BITS  unmasked result text
- core_tag  in  128  unmasked tag
- core_auth_ok  in  1  tag match; valid with core_done, decrypt only
- dout  out  W  output word
- dout_valid, dout_last  out  1  beat valid / final beat
- dout_ready  in  1  sink accept
- auth_fail  out  1  last decrypt failed; cleared on next launch
- err  out  1  sticky protocol error, cleared by rst only

## Operation
- States: IDLE, LOAD, ARMED, BUSY, UNLOAD.
- Load: a beat is accepted when din_valid && din_ready.
  - Each share register shifts MSB-first: f <= {f[len-W-1:0], share}.
  - Per-field word counter; loaded flag sets when the counter reaches len/W.
  - IDLE moves to LOAD on the first accepted beat.
- Overflow: a beat to an already-loaded field is dropped and sets err.
- ARMED: entered once all four loaded flags are set.
- Launch: in ARMED, exactly one of start_enc/start_dec goes to BUSY.
  - Both high at once: ignored, err set.
  - Start in any other state: ignored, err set.
- BUSY: waits for core_done, then latches core_text, core_tag and core_auth_ok into output shift registers.
- UNLOAD, encrypt: PT_BITS/W text words, then 128/W tag words, MSB-first.
- UNLOAD, decrypt: PT_BITS/W words only.
  - core_auth_ok=0: words are all zero and auth_fail=1.
- dout_last: high on the final word.
- Completion: last word accepted, then IDLE. All field registers, loaded flags and counters are cleared in the same cycle (no key retention).
- Field registers are frozen outside IDLE/LOAD; din_valid there is ignored with no err.

## Timing
- Reset: state IDLE; all registers, counters and flags 0.
  - Outputs: din_ready=1; core_start, core_dec, dout, dout_valid, dout_last, auth_fail, err all 0.
- Load throughput: one word per cycle. The loaded flag is visible the cycle after the last word. ARMED follows one cycle after the final flag sets.
- core_start: asserted the cycle after an accepted start, for exactly one cycle.
- First output: dout_valid=1 with the first word the cycle after core_done.
- Beat advance: on dout_valid && dout_ready. dout and dout_last hold stable while dout_ready=0.
- core_done outside BUSY: ignored, err set.
- rst mid-operation: any state returns to reset values on the next edge, with no partial output.

## Structure
- Shared package ascon_pkg:
  - state enum
  - field-select constants FLD_KEY/FLD_NONCE/FLD_AD/FLD_TEXT
  - NONCE_BITS=128, TAG_BITS=128
- One sub-module, ascon_share_shreg #(LEN, W, SHARES):
  - SHARES parallel MSB-first shift registers
  - word counter and loaded flag
  - synchronous clear
- Instantiated four times. Output serialiser stays inline.

## Test plan
All scenarios use W=8, SHARES=2, AD_BITS=32, PT_BITS=32.
- Load, shuffled order: 16 key, 16 nonce, 4 AD, 4 text words, interleaved across fields. key_sh share0 equals the sent bytes MSB-first; ARMED after the 40th beat plus 2 cycles.
- Encrypt: core model returns text 0xDEADBEEF and tag 0x00112233_44556677_8899AABB_CCDDEEFF. Stream is DE AD BE EF 00 11 … FF (20 beats), dout_last on beat 20, then IDLE with key_sh==0.
- Backpressure: dout_ready low for 3 cycles at beat 2. dout holds 0xAD; total beats still 20, no duplicates.
- Decrypt fail: core_auth_ok=0 with text 0x12345678. Output is 4 beats of 0x00 and auth_fail=1.
- Errors:
  - 5th AD word: dropped, err=1.
  - start_enc && start_dec in ARMED: stays ARMED, no core_start.
  - start_enc in LOAD: ignored, err=1.
- Reset mid-UNLOAD after beat 5: next cycle dout_valid=0, err=0, din_ready=1, all shares zero.
